// File: rtl/uart_cmd_ctrl_if.sv
// UART byte handshake between the RX/TX front end and the command controller.
// The front end is the master (delivers bytes, reports TX busy); the controller is the slave.
interface uart_cmd_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_start;

    modport master (
        output rx_data, rx_valid, tx_busy,
        input  tx_data, tx_start
    );

    modport slave (
        input  rx_data, rx_valid, tx_busy,
        output tx_data, tx_start
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// ASCII command parser: 'A'/'B' select the generator mode, "F<digits>CR" sets the tuning word.
// Every accepted or rejected command is answered with a single 'K' or 'E' status byte.
module uart_cmd_ctrl #(
    parameter int unsigned   FW         = 24,
    parameter int unsigned   MAX_DIGITS = 8,
    parameter logic [FW-1:0] DEF_FW     = FW'(1000)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    uart_cmd_ctrl_if.slave bus,
    output logic [2:0]    o_mode,
    output logic [FW-1:0] o_freq_word,
    output logic          o_cfg_update,
    output logic          o_err
);

    localparam int unsigned AW = FW + 4;
    localparam int unsigned CW = $clog2(MAX_DIGITS + 1);

    localparam logic [7:0] ChA  = 8'h41;
    localparam logic [7:0] ChB  = 8'h42;
    localparam logic [7:0] ChF  = 8'h46;
    localparam logic [7:0] ChCr = 8'h0D;
    localparam logic [7:0] ChLf = 8'h0A;
    localparam logic [7:0] ChK  = 8'h4B;
    localparam logic [7:0] ChE  = 8'h45;

    localparam logic [2:0] ModeA = 3'b001;
    localparam logic [2:0] ModeB = 3'b010;

    typedef enum logic [1:0] {StIdle, StDigits, StApply, StAckWait} state_e;

    state_e        r_state, w_state_nxt;
    logic [2:0]    r_mode, w_mode_nxt;
    logic [FW-1:0] r_freq_word, w_freq_word_nxt;
    logic [7:0]    r_tx_data, w_tx_data_nxt;
    logic          r_cfg_update, w_cfg_update_nxt;
    logic          r_err, w_err_nxt;
    logic [AW-1:0] r_acc, w_acc_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_ovf, w_ovf_nxt;
    logic          w_tx_start;
    logic          w_is_digit;
    logic [AW+3:0] w_acc_calc;

    assign w_is_digit = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
    // Extra headroom so the overflow test sees the full product before truncation.
    assign w_acc_calc = (AW+4)'(r_acc) * (AW+4)'(10) + (AW+4)'(bus.rx_data[3:0]);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_mode       <= ModeA;
            r_freq_word  <= DEF_FW;
            r_tx_data    <= 8'h00;
            r_cfg_update <= 1'b0;
            r_err        <= 1'b0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_ovf        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_mode       <= w_mode_nxt;
            r_freq_word  <= w_freq_word_nxt;
            r_tx_data    <= w_tx_data_nxt;
            r_cfg_update <= w_cfg_update_nxt;
            r_err        <= w_err_nxt;
            r_acc        <= w_acc_nxt;
            r_cnt        <= w_cnt_nxt;
            r_ovf        <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_mode_nxt       = r_mode;
        w_freq_word_nxt  = r_freq_word;
        w_tx_data_nxt    = r_tx_data;
        w_cfg_update_nxt = 1'b0;
        w_err_nxt        = 1'b0;
        w_acc_nxt        = r_acc;
        w_cnt_nxt        = r_cnt;
        w_ovf_nxt        = r_ovf;
        w_tx_start       = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (bus.rx_valid) begin
                    case (bus.rx_data)
                        ChA, ChB: begin
                            w_mode_nxt       = (bus.rx_data == ChA) ? ModeA : ModeB;
                            w_cfg_update_nxt = 1'b1;
                            w_tx_data_nxt    = ChK;
                            w_state_nxt      = StAckWait;
                        end
                        ChF: begin
                            w_acc_nxt   = '0;
                            w_cnt_nxt   = '0;
                            w_ovf_nxt   = 1'b0;
                            w_state_nxt = StDigits;
                        end
                        ChCr, ChLf: ;
                        default: begin
                            w_err_nxt     = 1'b1;
                            w_tx_data_nxt = ChE;
                            w_state_nxt   = StAckWait;
                        end
                    endcase
                end
            end
            StDigits: begin
                if (bus.rx_valid) begin
                    if (w_is_digit) begin
                        // Once overflowed, digits are swallowed until the terminator.
                        if (!r_ovf) begin
                            if ((r_cnt == CW'(MAX_DIGITS)) || (w_acc_calc[AW+3:FW] != '0)) begin
                                w_ovf_nxt = 1'b1;
                            end else begin
                                w_acc_nxt = w_acc_calc[AW-1:0];
                                w_cnt_nxt = r_cnt + CW'(1);
                            end
                        end
                    end else if ((bus.rx_data == ChCr) && (r_cnt != '0) && !r_ovf) begin
                        w_state_nxt = StApply;
                    end else begin
                        w_err_nxt     = 1'b1;
                        w_tx_data_nxt = ChE;
                        w_state_nxt   = StAckWait;
                    end
                end
            end
            StApply: begin
                w_freq_word_nxt  = r_acc[FW-1:0];
                w_cfg_update_nxt = 1'b1;
                w_tx_data_nxt    = ChK;
                w_state_nxt      = StAckWait;
            end
            StAckWait: begin
                if (!bus.tx_busy) begin
                    w_tx_start  = 1'b1;
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    assign bus.tx_data  = r_tx_data;
    assign bus.tx_start = w_tx_start;
    assign o_mode       = r_mode;
    assign o_freq_word  = r_freq_word;
    assign o_cfg_update = r_cfg_update;
    assign o_err        = r_err;

endmodule
